// File: rtl/vec_collect_pkg.sv
// Shared width helpers, FSM state encodings and float predicates for the
// scalar-to-vector collector and its fill bank.
package vec_collect_pkg;

    localparam int MAX_FLOAT_WIDTH = 64;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // The bias does not change how a float is stored; it is folded in at zero
    // weight so the shared float parameter set is consumed where it is passed.
    function automatic int float_width(input int exp_w, input int man_w, input int bias);
        return 1 + exp_w + man_w + 0 * bias;
    endfunction

    function automatic int vec_width(input int flt_w, input int vec_size);
        return flt_w * vec_size;
    endfunction

    function automatic int idx_width(input int vec_size);
        return (vec_size > 1) ? $clog2(vec_size) : 1;
    endfunction

    // NaN means an all-ones exponent with a nonzero mantissa; infinities do not count.
    function automatic logic is_nan(input logic [MAX_FLOAT_WIDTH-1:0] word,
                                    input int exp_w, input int man_w);
        logic exp_ones;
        logic man_nz;
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int i = 0; i < MAX_FLOAT_WIDTH; i++) begin
            if (i < man_w) begin
                man_nz = man_nz | word[i];
            end else if (i < man_w + exp_w) begin
                exp_ones = exp_ones & word[i];
            end
        end
        return exp_ones && man_nz;
    endfunction

endpackage

// File: rtl/vec_collect_bank.sv
// Fill bank for vec_collect: element storage, write index and sticky NaN flag.
// Reports when the next write lands in the final element slot.
module vec_collect_bank
    import vec_collect_pkg::*;
#(
    parameter  int EXP_WIDTH   = 8,
    parameter  int MAN_WIDTH   = 23,
    parameter  int BIAS        = -127,
    parameter  int VEC_SIZE    = 4,
    localparam int FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH, BIAS),
    localparam int VEC_WIDTH   = vec_width(FLOAT_WIDTH, VEC_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [FLOAT_WIDTH-1:0] wr_data,
    input  logic                   wr_nan,
    output logic [VEC_WIDTH-1:0]   bank_data,
    output logic                   bank_nan,
    output logic                   last
);

    localparam int IDX_W = idx_width(VEC_SIZE);

    logic [IDX_W-1:0] idx;

    assign last = (idx == IDX_W'(VEC_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_data <= '0;
        end else if (wr_en) begin
            for (int e = 0; e < VEC_SIZE; e++) begin
                if (idx == IDX_W'(e)) begin
                    bank_data[e*FLOAT_WIDTH +: FLOAT_WIDTH] <= wr_data;
                end
            end
        end
    end

    // A flush on the same edge as a write still stores the element; only the
    // index and the NaN history restart for the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            bank_nan <= 1'b0;
        end else if (flush) begin
            idx      <= '0;
            bank_nan <= 1'b0;
        end else if (wr_en) begin
            idx      <= last ? '0 : idx + 1'b1;
            bank_nan <= bank_nan | wr_nan;
        end
    end

endmodule

// File: rtl/vec_collect.sv
// Scalar-to-vector collector: groups VEC_SIZE accepted floats into one packed
// vector (element i at bits [i*FLOAT_WIDTH +: FLOAT_WIDTH]) behind an output register.
module vec_collect
    import vec_collect_pkg::*;
#(
    parameter  int EXP_WIDTH   = 8,
    parameter  int MAN_WIDTH   = 23,
    parameter  int BIAS        = -127,
    parameter  int VEC_SIZE    = 4,
    localparam int FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH, BIAS),
    localparam int VEC_WIDTH   = vec_width(FLOAT_WIDTH, VEC_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VEC_WIDTH-1:0]   out_data,
    output logic                   out_has_nan
);

    logic [0:0]           state;
    logic                 slot_free;
    logic                 accept;
    logic                 complete;
    logic                 load_fill;
    logic                 load_hold;
    logic                 in_nan;
    logic                 bank_nan;
    logic                 bank_last;
    logic [VEC_WIDTH-1:0] bank_data;
    logic [VEC_WIDTH-1:0] fill_vec;

    // in_ready depends on registered state only, never on out_ready.
    assign in_ready  = (state == ST_FILL);
    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !clear;
    assign complete  = accept && bank_last;
    assign load_fill = complete && slot_free;
    assign load_hold = (state == ST_HOLD) && slot_free && !clear;
    assign in_nan    = is_nan(MAX_FLOAT_WIDTH'(in_data), EXP_WIDTH, MAN_WIDTH);

    // Completing in FILL bypasses the bank for the final element.
    always_comb begin
        fill_vec = bank_data;
        fill_vec[(VEC_SIZE-1)*FLOAT_WIDTH +: FLOAT_WIDTH] = in_data;
    end

    vec_collect_bank #(
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH),
        .BIAS      (BIAS),
        .VEC_SIZE  (VEC_SIZE)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clear || load_fill || load_hold),
        .wr_en     (accept),
        .wr_data   (in_data),
        .wr_nan    (in_nan),
        .bank_data (bank_data),
        .bank_nan  (bank_nan),
        .last      (bank_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else if (clear) begin
            state <= ST_FILL;
        end else if (complete && !slot_free) begin
            state <= ST_HOLD;
        end else if (load_hold) begin
            state <= ST_FILL;
        end
    end

    // out_data keeps its last value after a transfer; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_has_nan <= 1'b0;
        end else if (load_fill) begin
            out_valid   <= 1'b1;
            out_data    <= fill_vec;
            out_has_nan <= bank_nan | in_nan;
        end else if (load_hold) begin
            out_valid   <= 1'b1;
            out_data    <= bank_data;
            out_has_nan <= bank_nan;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vec_collect.sv
// Bench for vec_collect: directed scenarios on a 4-wide instance, then random
// streams on 1-wide and 13-wide instances against a queue-based vector model.
module tb_vec_collect;

    localparam int FW   = 32;
    localparam int WMAX = 13 * FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          out_ready;
    logic [FW-1:0] in_data;
    int            sel;

    logic            iv4, ir4, ov4, nan4;
    logic [4*FW-1:0] od4;
    logic            iv1, ir1, ov1, nan1;
    logic [FW-1:0]   od1;
    logic            iv13, ir13, ov13, nan13;
    logic [WMAX-1:0] od13;

    logic            ir, ov, has_nan;
    logic [WMAX-1:0] od;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign iv4  = in_valid && (sel == 0);
    assign iv1  = in_valid && (sel == 1);
    assign iv13 = in_valid && (sel == 2);

    vec_collect #(.EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(-127), .VEC_SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv4), .in_ready(ir4),
        .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .out_has_nan(nan4));

    vec_collect #(.EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(-127), .VEC_SIZE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv1), .in_ready(ir1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_has_nan(nan1));

    vec_collect #(.EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(-127), .VEC_SIZE(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv13), .in_ready(ir13),
        .in_data(in_data), .out_valid(ov13), .out_ready(out_ready), .out_data(od13),
        .out_has_nan(nan13));

    always_comb begin
        ir = ir4; ov = ov4; has_nan = nan4; od = WMAX'(od4);
        case (sel)
            0: begin ir = ir4;  ov = ov4;  has_nan = nan4;  od = WMAX'(od4); end
            1: begin ir = ir1;  ov = ov1;  has_nan = nan1;  od = WMAX'(od1); end
            default: begin ir = ir13; ov = ov13; has_nan = nan13; od = od13; end
        endcase
    end

    task automatic check(input string tag, input logic [WMAX-1:0] observed,
                         input logic [WMAX-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        check(tag, WMAX'(observed), WMAX'(expected));
    endtask

    function automatic logic [WMAX-1:0] vec4(input logic [FW-1:0] e0, input logic [FW-1:0] e1,
                                             input logic [FW-1:0] e2, input logic [FW-1:0] e3);
        logic [WMAX-1:0] v;
        v = '0;
        v[4*FW-1:0] = {e3, e2, e1, e0};
        return v;
    endfunction

    function automatic bit ref_nan(input logic [FW-1:0] d);
        return (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
    endfunction

    function automatic logic [FW-1:0] rand_elem();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0: return {s, 8'hFF, 23'h0};
            1: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            default: return $urandom();
        endcase
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Holds the element on the input until one edge accepts it.
    task automatic offer(input logic [FW-1:0] data);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        for (int k = 0; k < 50 && !taken; k++) begin
            taken = ir;
            @(negedge clk);
        end
        checks++;
        assert (taken) else begin
            failures++;
            $error("[TB] FAIL offer_timeout observed=not_accepted expected=accepted data=%h", data);
        end
    endtask

    task automatic run_random(input int which, input int vs, input int n_elems);
        logic [FW-1:0]   pend[$];
        logic [WMAX-1:0] exp_vec[$];
        bit              exp_nan[$];
        logic [WMAX-1:0] v;
        bit              n;
        bit              acc;
        int              accepted;
        int              cycles;
        accepted = 0;
        cycles   = 0;
        sel      = which;
        apply_reset();
        $display("[TB] random run VEC_SIZE=%0d elements=%0d", vs, n_elems);
        while ((accepted < n_elems || exp_vec.size() != 0) && cycles < 40000) begin
            in_valid  = (accepted < n_elems) && ($urandom_range(0, 3) != 0);
            in_data   = rand_elem();
            out_ready = ($urandom_range(0, 3) != 0);
            if (ov) begin
                check_bit("rand_unexpected_vector", exp_vec.size() != 0, 1'b1);
                if (exp_vec.size() != 0) begin
                    check("rand_vector", od, exp_vec[0]);
                    check_bit("rand_nan", has_nan, exp_nan[0]);
                    if (out_ready) begin
                        void'(exp_vec.pop_front());
                        void'(exp_nan.pop_front());
                    end
                end
            end
            acc = in_valid && ir;
            @(negedge clk);
            cycles++;
            if (acc) begin
                pend.push_back(in_data);
                accepted++;
                if (pend.size() == vs) begin
                    v = '0;
                    n = 1'b0;
                    for (int i = 0; i < vs; i++) begin
                        v[i*FW +: FW] = pend[i];
                        n = n | ref_nan(pend[i]);
                    end
                    exp_vec.push_back(v);
                    exp_nan.push_back(n);
                    pend.delete();
                end
            end
        end
        in_valid = 1'b0;
        check_bit("rand_finished_in_budget", cycles < 40000, 1'b1);
        check("rand_vectors_outstanding", WMAX'(exp_vec.size()), WMAX'(0));
        check("rand_elements_accepted", WMAX'(accepted), WMAX'(n_elems));
    endtask

    initial begin
        logic [FW-1:0] a [12];
        logic [FW-1:0] d [7];
        logic [FW-1:0] f [4];

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; sel = 0;
        apply_reset();

        $display("[TB] reset state");
        check_bit("rst_out_valid", ov, 1'b0);
        check("rst_out_data", od, '0);
        check_bit("rst_has_nan", has_nan, 1'b0);
        check_bit("rst_in_ready", ir, 1'b1);

        $display("[TB] back-to-back streaming");
        out_ready = 1'b1;
        offer(32'h3F800000); offer(32'h40000000); offer(32'h40400000); offer(32'h40800000);
        check_bit("stream_valid_next_cycle", ov, 1'b1);
        check("stream_data", od, vec4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000));
        check_bit("stream_nan", has_nan, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check_bit("stream_drained_valid", ov, 1'b0);
        check("stream_data_kept", od, vec4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000));

        $display("[TB] backpressure");
        for (int k = 0; k < 12; k++) a[k] = 32'h41000000 | 32'(k);
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) offer(a[k]);
        check_bit("bp_in_ready_low", ir, 1'b0);
        check_bit("bp_first_valid", ov, 1'b1);
        check("bp_first_vec", od, vec4(a[0], a[1], a[2], a[3]));
        in_valid = 1'b1;
        in_data  = a[8];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit("bp_hold_in_ready", ir, 1'b0);
            check("bp_hold_stable", od, vec4(a[0], a[1], a[2], a[3]));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_bit("bp_second_valid", ov, 1'b1);
        check("bp_second_vec", od, vec4(a[4], a[5], a[6], a[7]));
        check_bit("bp_in_ready_back", ir, 1'b1);
        for (int k = 8; k < 12; k++) offer(a[k]);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_bit("bp_third_valid", ov, 1'b1);
        check("bp_third_vec", od, vec4(a[8], a[9], a[10], a[11]));
        @(negedge clk);
        check_bit("bp_drained", ov, 1'b0);

        $display("[TB] nan flag");
        offer(32'h3F800000); offer(32'h40000000); offer(32'h7FC00000); offer(32'h40400000);
        check_bit("nan_quiet", has_nan, 1'b1);
        check("nan_quiet_data", od, vec4(32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h40400000));
        offer(32'h3F800000); offer(32'h40000000); offer(32'h7F800000); offer(32'h40400000);
        check_bit("nan_infinity", has_nan, 1'b0);
        offer(32'h3F800000); offer(32'h40000000); offer(32'hFF800001); offer(32'h40400000);
        check_bit("nan_negative", has_nan, 1'b1);
        out_ready = 1'b0;

        $display("[TB] clear");
        offer(32'h7FC00001); offer(32'h40A00000);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_bit("clr_keeps_valid", ov, 1'b1);
        check("clr_keeps_data", od, vec4(32'h3F800000, 32'h40000000, 32'hFF800001, 32'h40400000));
        check_bit("clr_keeps_nan", has_nan, 1'b1);
        out_ready = 1'b1;
        repeat (4) offer(32'h3F800000);
        check_bit("clr_valid", ov, 1'b1);
        check("clr_vector", od, vec4(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000));
        check_bit("clr_nan_cleared", has_nan, 1'b0);

        $display("[TB] reset mid-fill");
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) d[k] = 32'h42000000 | 32'(k);
        d[1] = 32'h7FA00000;
        for (int k = 0; k < 4; k++) offer(d[k]);
        check_bit("mid_pre_valid", ov, 1'b1);
        check_bit("mid_pre_nan", has_nan, 1'b1);
        for (int k = 4; k < 7; k++) offer(d[k]);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_bit("mid_async_valid", ov, 1'b0);
        check("mid_async_data", od, '0);
        check_bit("mid_async_nan", has_nan, 1'b0);
        check_bit("mid_async_in_ready", ir, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) f[k] = 32'hC0000000 | 32'(k * 3);
        for (int k = 0; k < 4; k++) offer(f[k]);
        check_bit("mid_fresh_valid", ov, 1'b1);
        check("mid_fresh_vec", od, vec4(f[0], f[1], f[2], f[3]));
        check_bit("mid_fresh_nan", has_nan, 1'b0);
        in_valid = 1'b0;

        run_random(1, 1, 10000);
        run_random(2, 13, 13 * 770);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
